// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int   NUM_PORTS = 2;
   localparam logic PORT0     = 1'b0;
   localparam logic PORT1     = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational two-way request picker.
// MEM_ARBITER_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module rr_picker
   import mem_arbiter_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 last_grant_i,
   output logic                 valid_o,
   output logic                 port_o
);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
   logic unused_last_grant_s;
   assign unused_last_grant_s = last_grant_i;
`endif

   // Choose the winning port; on a tie either port 0 or the port not granted last.
   always_comb begin
      valid_o = |req_i;
      port_o  = PORT0;
      case (req_i)
         2'b01:   port_o = PORT0;
         2'b10:   port_o = PORT1;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
         2'b11:   port_o = PORT0;
`else
         2'b11:   port_o = ~last_grant_i;
`endif
         default: port_o = PORT0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port memory with ready handshake.
// Build option: MEM_ARBITER_FIXED_PRIO_EN (fixed port-0 priority, see rr_picker).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  p0_req_in,
   input  logic                  p0_write_in,
   input  logic [DATA_WIDTH-1:0] p0_addr_in,
   input  logic [DATA_WIDTH-1:0] p0_data_in,
   input  logic                  p1_req_in,
   input  logic                  p1_write_in,
   input  logic [DATA_WIDTH-1:0] p1_addr_in,
   input  logic [DATA_WIDTH-1:0] p1_data_in,
   output logic                  p0_ack_out,
   output logic                  p1_ack_out,
   output logic [DATA_WIDTH-1:0] rdata_out,
   output logic                  busy_out,
   output logic                  mem_enable_out,
   output logic                  mem_write_out,
   output logic [DATA_WIDTH-1:0] mem_addr_out,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_ready_in,
   input  logic [DATA_WIDTH-1:0] mem_data_in
);

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  wr_q, wr_d;
   logic                  enable_q, enable_d;
   logic                  mem_write_q, mem_write_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  busy_q, busy_d;

   logic                  pick_valid_s;
   logic                  pick_port_s;
   logic                  ready_ok_s;

   // A floating or unknown ready line must read as "not ready".
   assign ready_ok_s = (mem_ready_in === 1'b1);

   rr_picker u_picker (
      .req_i        ({p1_req_in, p0_req_in}),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid_s),
      .port_o       (pick_port_s)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (ready_ok_s) begin
               state_d = RESP;
            end else begin
               state_d = ISSUE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of all registered outputs and the latched access.
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      data_d       = data_q;
      rdata_d      = rdata_q;
      enable_d     = 1'b0;
      mem_write_d  = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      busy_d       = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               grant_d      = pick_port_s;
               last_grant_d = pick_port_s;
               wr_d         = (pick_port_s == PORT1) ? p1_write_in : p0_write_in;
               addr_d       = (pick_port_s == PORT1) ? p1_addr_in  : p0_addr_in;
               data_d       = (pick_port_s == PORT1) ? p1_data_in  : p0_data_in;
               enable_d     = 1'b1;
               mem_write_d  = wr_d;
            end else begin
               enable_d     = 1'b0;
            end
         end
         WAIT: begin
            if (ready_ok_s) begin
               rdata_d = mem_data_in;
               if (grant_q == PORT1) begin
                  ack1_d = 1'b1;
               end else begin
                  ack0_d = 1'b1;
               end
            end else begin
               enable_d    = 1'b1;
               mem_write_d = wr_q;
            end
         end
         ISSUE:   enable_d = 1'b0;
         RESP:    enable_d = 1'b0;
         default: enable_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         grant_q      <= PORT0;
         last_grant_q <= PORT1;
         wr_q         <= 1'b0;
         enable_q     <= 1'b0;
         mem_write_q  <= 1'b0;
         addr_q       <= {DATA_WIDTH{1'b0}};
         data_q       <= {DATA_WIDTH{1'b0}};
         rdata_q      <= {DATA_WIDTH{1'b0}};
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
         enable_q     <= enable_d;
         mem_write_q  <= mem_write_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         rdata_q      <= rdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
      end
   end

   assign p0_ack_out     = ack0_q;
   assign p1_ack_out     = ack1_q;
   assign rdata_out      = rdata_q;
   assign busy_out       = busy_q;
   assign mem_enable_out = enable_q;
   assign mem_write_out  = mem_write_q;
   assign mem_addr_out   = addr_q;
   assign mem_data_out   = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p0_req = 1'b0, p0_write = 1'b0;
   logic [31:0] p0_addr = 32'h0, p0_data = 32'h0;
   logic        p1_req = 1'b0, p1_write = 1'b0;
   logic [31:0] p1_addr = 32'h0, p1_data = 32'h0;
   logic        p0_ack, p1_ack, busy, mem_en, mem_wr;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic        force_z = 1'b0;
   logic        rdy_q;
   logic [31:0] rd_q;
   logic [31:0] mem [0:7];
   wire         mem_ready_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mem_ready_w = force_z ? 1'bz : rdy_q;

   // Behavioural memory: samples enable, returns the old word with ready one cycle later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
         mem[5] <= 32'hDEADBEEF;
         rdy_q  <= 1'b0;
         rd_q   <= 32'h0;
      end else begin
         rdy_q <= 1'b0;
         if (mem_en) begin
            rd_q  <= mem[mem_addr[2:0]];
            rdy_q <= 1'b1;
            if (mem_wr) mem[mem_addr[2:0]] <= mem_wdata;
         end
      end
   end

   mem_arbiter #(.DATA_WIDTH(32)) dut (
      .clk_in(clk), .rst_n_in(rst_n),
      .p0_req_in(p0_req), .p0_write_in(p0_write), .p0_addr_in(p0_addr), .p0_data_in(p0_data),
      .p1_req_in(p1_req), .p1_write_in(p1_write), .p1_addr_in(p1_addr), .p1_data_in(p1_data),
      .p0_ack_out(p0_ack), .p1_ack_out(p1_ack), .rdata_out(rdata), .busy_out(busy),
      .mem_enable_out(mem_en), .mem_write_out(mem_wr),
      .mem_addr_out(mem_addr), .mem_data_out(mem_wdata),
      .mem_ready_in(mem_ready_w), .mem_data_in(rd_q)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access from an idle arbiter; returns ack latency in cycles after the grant edge.
   task automatic access(input int port, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic glitch,
                         output int lat, output logic [31:0] rd, output int en_cnt);
      logic got;
      got = 1'b0; lat = -1; rd = 32'h0; en_cnt = 0;
      @(negedge clk);
      if (port == 0) begin
         p0_req = 1'b1; p0_write = wr; p0_addr = addr; p0_data = data;
      end else begin
         p1_req = 1'b1; p1_write = wr; p1_addr = addr; p1_data = data;
      end
      @(posedge clk);
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (glitch && j == 0) force_z = 1'b1;
         if (j == 2) force_z = 1'b0;
         if (j == 0) begin
            chk("issue_addr", mem_addr, addr);
            chk("issue_write", {31'h0, mem_wr}, {31'h0, wr});
         end
         if (mem_en) en_cnt++;
         if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
            lat = j; rd = rdata; got = 1'b1;
            break;
         end
      end
      chk("ack_seen", {31'h0, got}, 32'h1);
      p0_req = 1'b0; p1_req = 1'b0;
   endtask

   int          lat, en_cnt;
   logic [31:0] rd;
   int          order [0:3];
   logic        got;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_en", {31'h0, mem_en}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      // Reset while in WAIT: outputs clear immediately, no ack afterwards
      @(negedge clk);
      p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'd5;
      @(negedge clk);
      chk("pre_busy", {31'h0, busy}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_en", {31'h0, mem_en}, 32'h0);
      chk("midrst_ack", {30'h0, p1_ack, p0_ack}, 32'h0);
      chk("midrst_addr", mem_addr, 32'h0);
      p0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      got = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (p0_ack || p1_ack || busy) got = 1'b1;
      end
      chk("no_ack_after_rst", {31'h0, got}, 32'h0);

      // Single read from port 0
      access(0, 1'b0, 32'd5, 32'h0, 1'b0, lat, rd, en_cnt);
      chk("rd_lat", lat, 32'd2);
      chk("rd_en_cycles", en_cnt, 32'd1);
      chk("rd_data", rd, 32'hDEADBEEF);
      @(negedge clk);
      chk("ack_clear", {30'h0, p1_ack, p0_ack}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("rdata_hold", rdata, 32'hDEADBEEF);

      // Write then read on port 1
      access(1, 1'b1, 32'd7, 32'h12345678, 1'b0, lat, rd, en_cnt);
      chk("wr_lat", lat, 32'd2);
      chk("wr_old_data", rd, 32'h0);
      access(1, 1'b0, 32'd7, 32'h0, 1'b0, lat, rd, en_cnt);
      chk("rdback_data", rd, 32'h12345678);

      // Ready floating on first WAIT forces one retry
      access(0, 1'b0, 32'd5, 32'h0, 1'b1, lat, rd, en_cnt);
      chk("glitch_lat", lat, 32'd4);
      chk("glitch_en_cycles", en_cnt, 32'd2);
      chk("glitch_data", rd, 32'hDEADBEEF);

      // Back-to-back: p1 asks in p0's ack cycle, wins at N+4
      access(0, 1'b0, 32'd5, 32'h0, 1'b0, lat, rd, en_cnt);
      p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'd7;
      @(negedge clk);
      chk("b2b_gap_busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      chk("b2b_busy", {31'h0, busy}, 32'h1);
      chk("b2b_addr", mem_addr, 32'd7);
      repeat (2) @(negedge clk);
      chk("b2b_ack", {30'h0, p1_ack, p0_ack}, 32'h2);
      chk("b2b_data", rdata, 32'h12345678);
      p1_req = 1'b0;
      @(negedge clk);

      // Contention: both ports request continuously
      p0_req = 1'b1; p0_write = 1'b0; p0_addr = 32'd5;
      p1_req = 1'b1; p1_write = 1'b0; p1_addr = 32'd7;
      for (int t = 0; t < 4; t++) begin
         order[t] = -1;
         for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
               order[t] = p1_ack ? 1 : 0;
               chk("cont_data", rdata, p1_ack ? 32'h12345678 : 32'hDEADBEEF);
               break;
            end
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
      chk("cont_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00000000);
`else
      chk("cont_order", {order[0][7:0], order[1][7:0], order[2][7:0], order[3][7:0]}, 32'h00010001);
`endif
      repeat (4) @(negedge clk);
      chk("final_busy", {31'h0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
